mod_intc: RTL and testbench

Parametrised vectored interrupt controller. It replaces the fixed four-source controller on the data bus and takes up to 31 peripheral interrupt lines, each individually configurable as edge- or level-sensitive. It resolves them by fixed priority and presents a single `int` request plus a latched vector number to the CPU, using an `int`/`int_ack` handshake. Software sees mask, status, mode and vector registers in a 16-byte memory-mapped window.

---
 rtl/mod_intc_pkg.sv | 17 +
 rtl/mod_intc_prio_enc.sv | 22 ++
 rtl/mod_intc.sv | 119 +++++++++++
 tb/tb_mod_intc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_intc_pkg.sv
// Shared definitions for the vectored interrupt controller: register map,
// handshake FSM encoding and the GIE bit position.
package mod_intc_pkg;

   localparam logic [31:0] INTC_MASK   = 32'h0;
   localparam logic [31:0] INTC_STATUS = 32'h4;
   localparam logic [31:0] INTC_MODE   = 32'h8;
   localparam logic [31:0] INTC_VEC    = 32'hC;

   localparam int GIE_BIT = 0;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } intc_state_e;

endpackage

// File: rtl/mod_intc_prio_enc.sv
// Lowest-index-first priority encoder; idx is 1-based (bit 0 of req -> 1).
module intc_prio_enc #(
   parameter int N = 4,
   parameter int W = 5
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[k]) begin
            idx   = W'(k + 1);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mod_intc.sv
// Vectored interrupt controller: edge/level sources, fixed priority, int/ack
// handshake and a 16-byte register window. State updates on the falling edge.
//
// state    | meaning
// IDLE     | no request outstanding; arbitrate when GIE=1 and a source is eligible
// WAIT_ACK | int_req high, int_vec frozen until int_ack
module mod_intc
   import mod_intc_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int VEC_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ie,
   input  logic              de,
   input  logic [31:0]       iaddr,
   input  logic [31:0]       daddr,
   input  logic [1:0]        drw,
   input  logic [31:0]       din,
   output logic [31:0]       iout,
   output logic [31:0]       dout,
   input  logic [N_SRC-1:0]  irq_src,
   output logic              int_req,
   input  logic              int_ack,
   output logic [VEC_W-1:0]  int_vec
);

   intc_state_e         state, state_nxt;
   logic [N_SRC:0]      mask_q;
   logic [N_SRC-1:0]    status_q, mode_q, irq_prev;
   logic [N_SRC-1:0]    status_nxt, eligible, ack_clr, w1c, edge_set, edge_keep;
   logic [VEC_W-1:0]    vec_nxt, win_idx;
   logic                win_valid, ack_fire, gie_force_clr;
   logic                wr_mask, wr_status, wr_mode;
   logic                unused_bus;

   assign unused_bus = ^{ie, iaddr, drw[1]};
   assign iout       = 32'h0;

   assign wr_mask   = de && drw[0] && (daddr == INTC_MASK);
   assign wr_status = de && drw[0] && (daddr == INTC_STATUS);
   assign wr_mode   = de && drw[0] && (daddr == INTC_MODE);

   assign eligible = status_q & mask_q[N_SRC:1];

   intc_prio_enc #(.N(N_SRC), .W(VEC_W)) u_prio (
      .req   (eligible),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_comb begin
      state_nxt     = state;
      vec_nxt       = int_vec;
      gie_force_clr = 1'b0;
      ack_fire      = 1'b0;
      case (state)
         IDLE: begin
            if (mask_q[GIE_BIT] && win_valid) begin
               state_nxt     = WAIT_ACK;
               vec_nxt       = win_idx;
               gie_force_clr = 1'b1;
            end
         end
         WAIT_ACK: begin
            if (int_ack) begin
               state_nxt = IDLE;
               ack_fire  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Hardware set beats software clear; level sources simply follow the line.
   always_comb begin
      ack_clr = '0;
      for (int k = 0; k < N_SRC; k++) begin
         ack_clr[k] = ack_fire && mode_q[k] && (int_vec == VEC_W'(k + 1));
      end
      w1c        = wr_status ? din[N_SRC:1] : '0;
      edge_set   = irq_src & ~irq_prev;
      edge_keep  = status_q & ~(w1c | ack_clr);
      status_nxt = (mode_q & (edge_set | edge_keep)) | (~mode_q & irq_src);
   end

   always_ff @(negedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         mask_q   <= '0;
         mode_q   <= '0;
         status_q <= '0;
         irq_prev <= '0;
         int_vec  <= '0;
      end else begin
         state    <= state_nxt;
         int_vec  <= vec_nxt;
         status_q <= status_nxt;
         irq_prev <= irq_src;
         if (wr_mode) mode_q <= din[N_SRC:1];
         if (wr_mask) mask_q <= din[N_SRC:0];
         if (gie_force_clr) mask_q[GIE_BIT] <= 1'b0;
      end
   end

   assign int_req = (state == WAIT_ACK);

   always_comb begin
      case (daddr)
         INTC_MASK:   dout = 32'(mask_q);
         INTC_STATUS: dout = 32'({status_q, 1'b1});
         INTC_MODE:   dout = 32'({mode_q, 1'b0});
         INTC_VEC:    dout = {int_req, {(31 - VEC_W){1'b0}}, int_vec};
         default:     dout = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_mod_intc.sv
// Directed scoreboard bench for mod_intc: expected values are queued as
// stimulus is applied and compared when the DUT output is sampled.
module tb_mod_intc;
   import mod_intc_pkg::*;

   localparam int N_SRC = 4;
   localparam int VEC_W = 5;

   logic              clk = 1'b1;
   logic              rst;
   logic              ie, de;
   logic [31:0]       iaddr, daddr, din;
   logic [1:0]        drw;
   logic [31:0]       iout, dout;
   logic [N_SRC-1:0]  irq_src;
   logic              int_req, int_ack;
   logic [VEC_W-1:0]  int_vec;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   mod_intc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .ie      (ie),
      .de      (de),
      .iaddr   (iaddr),
      .daddr   (daddr),
      .drw     (drw),
      .din     (din),
      .iout    (iout),
      .dout    (dout),
      .irq_src (irq_src),
      .int_req (int_req),
      .int_ack (int_ack),
      .int_vec (int_vec)
   );

   always #10 clk = ~clk;

   // One state update happens at the negedge; return at the following posedge.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty: got %h want <entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      daddr = addr;
      push(tag, exp);
      #1;
      pop_cmp(dout);
   endtask

   task automatic chk_int(input logic exp_int, input logic [VEC_W-1:0] exp_vec, input string tag);
      push({tag, "_int"}, {31'h0, exp_int});
      push({tag, "_vec"}, 32'(exp_vec));
      #1;
      pop_cmp({31'h0, int_req});
      pop_cmp(32'(int_vec));
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      de    = 1'b1;
      drw   = 2'b01;
      daddr = addr;
      din   = data;
      tick();
      de    = 1'b0;
      drw   = 2'b00;
      din   = 32'h0;
   endtask

   initial begin
      rst = 1'b0; ie = 1'b0; de = 1'b0; iaddr = 32'h0; daddr = 32'h0;
      din = 32'h0; drw = 2'b00; irq_src = '0; int_ack = 1'b0;
      tick();
      tick();
      rst = 1'b1;

      // reset state
      rd(INTC_MASK,   32'h0, "rst_mask");
      rd(INTC_STATUS, 32'h1, "rst_status");
      rd(INTC_MODE,   32'h0, "rst_mode");
      rd(INTC_VEC,    32'h0, "rst_vec");
      push("rst_iout", 32'h0);
      pop_cmp(iout);
      chk_int(1'b0, '0, "rst");

      // single edge source, one-cycle latency to int
      wr(INTC_MODE, 32'h1E);
      wr(INTC_MASK, 32'h1F);
      rd(INTC_MODE, 32'h1E, "mode_rw");
      irq_src = 4'b0100;
      tick();
      irq_src = '0;
      chk_int(1'b0, '0, "edge_same_cycle");
      rd(INTC_STATUS, 32'h9, "edge_pending");
      tick();
      chk_int(1'b1, 5'd3, "edge_req");
      rd(INTC_MASK, 32'h1E, "gie_cleared");
      rd(INTC_VEC, 32'h8000_0003, "vec_reg");
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk_int(1'b0, 5'd3, "ack1");
      rd(INTC_STATUS, 32'h1, "ack1_autoclr");

      // two simultaneous sources resolve in priority order
      wr(INTC_MASK, 32'h1F);
      irq_src = 4'b1010;
      tick();
      irq_src = '0;
      rd(INTC_STATUS, 32'h15, "two_pending");
      tick();
      chk_int(1'b1, 5'd2, "prio_first");
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      rd(INTC_STATUS, 32'h11, "prio_remaining");
      wr(INTC_MASK, 32'h1F);
      tick();
      chk_int(1'b1, 5'd4, "prio_second");
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      rd(INTC_STATUS, 32'h1, "prio_drained");

      // level source ignores W1C while the line is high
      wr(INTC_MODE, 32'h1C);
      irq_src = 4'b0001;
      tick();
      rd(INTC_STATUS, 32'h3, "level_high");
      wr(INTC_STATUS, 32'h2);
      rd(INTC_STATUS, 32'h3, "level_w1c_noeffect");
      chk_int(1'b0, 5'd4, "level_gie_off");
      irq_src = '0;
      tick();
      rd(INTC_STATUS, 32'h1, "level_low");

      // edge set coinciding with W1C: set wins; a plain W1C then clears
      wr(INTC_MODE, 32'h1E);
      irq_src = 4'b0001;
      wr(INTC_STATUS, 32'h2);
      irq_src = '0;
      rd(INTC_STATUS, 32'h3, "set_beats_clr");
      wr(INTC_STATUS, 32'h2);
      rd(INTC_STATUS, 32'h1, "w1c_clears");
      rd(32'h10, 32'h0, "unmapped_offset");

      // vector frozen during WAIT_ACK, then reset mid-handshake
      wr(INTC_MASK, 32'h1F);
      irq_src = 4'b0100;
      tick();
      irq_src = '0;
      tick();
      chk_int(1'b1, 5'd3, "hold_req");
      irq_src = 4'b0001;
      tick();
      irq_src = '0;
      tick();
      chk_int(1'b1, 5'd3, "hold_vec_stable");
      rd(INTC_STATUS, 32'hB, "hold_new_pending");
      rst = 1'b0;
      tick();
      chk_int(1'b0, '0, "midrst");
      rd(INTC_MASK,   32'h0, "midrst_mask");
      rd(INTC_STATUS, 32'h1, "midrst_status");
      rd(INTC_MODE,   32'h0, "midrst_mode");
      rst = 1'b1;

      // ack while idle has no effect
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
      chk_int(1'b0, '0, "idle_ack");

      if (sb.size() != 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_leftover: got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
